// File: rtl/sobel_pkg.sv
// Shared types and size helpers for the Sobel window path.
package sobel_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        SCAN  = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int addr_width(input int h, input int v);
        return $clog2(h * v);
    endfunction

    function automatic int win_count(input int h, input int v);
        return (h - 2) * (v - 2);
    endfunction

endpackage

// File: rtl/frame_sequencer.sv
// Frame-level controller: loads one frame into the frame RAM, then releases the
// window separator to scan it and counts accepted windows until the frame is done.
module frame_sequencer
    import sobel_pkg::*;
#(
    parameter int horiz_width_p         = 4,
    parameter int vertic_width_p        = 4,
    parameter int color_channel_width_p = 4,
    localparam int aw = addr_width(horiz_width_p, vertic_width_p)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             start_i,
    input  logic                             abort_i,
    input  logic                             pix_valid_i,
    input  logic [color_channel_width_p-1:0] pix_data_i,
    output logic                             pix_ready_o,
    output logic                             wr_en_o,
    output logic [aw-1:0]                    wr_addr_o,
    output logic [color_channel_width_p-1:0] wr_data_o,
    output logic                             sep_reset_o,
    input  logic                             win_valid_i,
    input  logic                             win_ready_i,
    output logic                             busy_o,
    output logic                             done_o,
    output logic [7:0]                       frame_cnt_o,
    output logic [2:0]                       dbg_state_o
);

    localparam int n_pix = horiz_width_p * vertic_width_p;
    localparam int n_win = win_count(horiz_width_p, vertic_width_p);
    localparam int pcw   = aw + 1;
    localparam int wcw   = $clog2(n_win + 1);

    // Handshakes: a transfer happens on a cycle where valid and ready are both
    // high at the rising edge; valid never waits on ready.
    state_t                           r_state;
    state_t                           w_next;
    logic [pcw-1:0]                   r_pix_cnt;
    logic [wcw-1:0]                   r_win_cnt;
    logic                             r_pix_ready;
    logic                             r_wr_en;
    logic [aw-1:0]                    r_wr_addr;
    logic [color_channel_width_p-1:0] r_wr_data;
    logic                             r_sep_reset;
    logic                             r_busy;
    logic                             r_done;
    logic [7:0]                       r_frame_cnt;
    logic                             w_pix_acc;
    logic                             w_win_acc;

    // r_pix_ready is high exactly while in LOAD, so it doubles as the LOAD qualifier.
    assign w_pix_acc = r_pix_ready & pix_valid_i;
    assign w_win_acc = (r_state == SCAN) & win_valid_i & win_ready_i;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start_i) w_next = LOAD;
            LOAD:    if (w_pix_acc && r_pix_cnt == pcw'(n_pix - 1)) w_next = FLUSH;
            FLUSH:   w_next = SCAN;
            SCAN:    if (w_win_acc && r_win_cnt == wcw'(n_win - 1)) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
        if (abort_i) w_next = IDLE;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state     <= IDLE;
            r_pix_cnt   <= '0;
            r_win_cnt   <= '0;
            r_pix_ready <= 1'b0;
            r_wr_en     <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_sep_reset <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            // Outputs are decoded from the next state so they line up with r_state.
            r_state     <= w_next;
            r_pix_ready <= (w_next == LOAD);
            r_sep_reset <= (w_next != SCAN);
            r_busy      <= (w_next != IDLE);
            r_done      <= (w_next == DONE);
            r_wr_en     <= w_pix_acc;
            if (w_pix_acc) begin
                r_wr_addr <= r_pix_cnt[aw-1:0];
                r_wr_data <= pix_data_i;
                r_pix_cnt <= r_pix_cnt + 1'b1;
            end
            if (w_win_acc) r_win_cnt <= r_win_cnt + 1'b1;
            if (r_state == IDLE && start_i) begin
                r_pix_cnt <= '0;
                r_win_cnt <= '0;
            end
            if (w_next == DONE) r_frame_cnt <= r_frame_cnt + 8'd1;
        end
    end

    assign pix_ready_o = r_pix_ready;
    assign wr_en_o     = r_wr_en;
    assign wr_addr_o   = r_wr_addr;
    assign wr_data_o   = r_wr_data;
    assign sep_reset_o = r_sep_reset;
    assign busy_o      = r_busy;
    assign done_o      = r_done;
    assign frame_cnt_o = r_frame_cnt;
    assign dbg_state_o = r_state;

endmodule

// File: doc/frame_sequencer.md
# frame_sequencer

Frame-level controller for the Sobel window path. Accepts one frame of pixels from an upstream stream, writes them into the frame RAM, then releases the 3x3 window separator to scan the RAM. It counts accepted windows and signals frame completion. It owns the RAM write port and the separator's synchronous reset, so the frame RAM is never written while windows are being read.

## Interface
Parameters:
- horiz_width_p, default 4: frame width in pixels, must be ≥ 3.
- vertic_width_p, default 4: frame height in pixels, must be ≥ 3.
- color_channel_width_p, default 4: pixel width in bits.

Derived widths:
- aw = $clog2(horiz_width_p*vertic_width_p).
- N = horiz_width_p*vertic_width_p pixels per frame.
- W = (horiz_width_p-2)*(vertic_width_p-2) windows per frame.

Ports:
- clk_i, in, 1: single clock.
- reset_i, in, 1: asynchronous, active-high reset.
- start_i, in, 1: frame start request; sampled only in IDLE.
- abort_i, in, 1: synchronous abort, honoured in any state.
- pix_valid_i, in, 1: upstream pixel valid.
- pix_data_i, in, color_channel_width_p: upstream pixel.
- pix_ready_o, out, 1: pixel accept.
- wr_en_o, out, 1: frame RAM write enable.
- wr_addr_o, out, aw: frame RAM write address.
- wr_data_o, out, color_channel_width_p: frame RAM write data.
- sep_reset_o, out, 1: synchronous reset to the separator.
- win_valid_i, in, 1: separator output valid (monitor tap).
- win_ready_i, in, 1: downstream ready for separator output (monitor tap).
- busy_o, out, 1: high in any state other than IDLE.
- done_o, out, 1: one-cycle pulse at frame completion.
- frame_cnt_o, out, 8: completed-frame count; wraps 255→0.

## Operation
- States: IDLE, LOAD, FLUSH, SCAN, DONE.
- IDLE: pix_ready_o=0, sep_reset_o=1. If start_i=1, go to LOAD and clear the pixel and window counters.
- LOAD: pix_ready_o=1.
  - A pixel is accepted when pix_valid_i & pix_ready_o.
  - Each accepted pixel is written to address = pixel counter, then the counter increments.
  - Acceptance of pixel N-1 moves to FLUSH.
- FLUSH: pix_ready_o=0. The last RAM write lands this cycle. Go to SCAN.
- SCAN: sep_reset_o=0.
  - A window is counted on win_valid_i & win_ready_i only; valid without ready is not counted.
  - Handshake number W moves to DONE.
- DONE: done_o=1, sep_reset_o=1, frame_cnt_o increments. Go to IDLE. start_i in DONE is ignored.
- abort_i=1 in any state:
  - Next state is IDLE; no done_o pulse; frame_cnt_o unchanged.
  - A RAM write already registered from the previous cycle still completes.
  - abort_i has priority over all other transitions.
- Window handshakes outside SCAN are ignored.
- Pixel counter width is aw+1 and window counter width is $clog2(W+1), so no wrap occurs within a frame.

## Timing
- Reset values: pix_ready_o=0, wr_en_o=0, wr_addr_o=0, wr_data_o=0, sep_reset_o=1, busy_o=0, done_o=0, frame_cnt_o=0, state IDLE.
- All outputs are registered; none depend combinationally on inputs.
- start_i sampled in IDLE at cycle n: busy_o=1 and pix_ready_o=1 at n+1.
- Pixel accepted at cycle k: wr_en_o=1 with that address and data at k+1.
- Last pixel accepted at k:
  - FLUSH at k+1, with the last write.
  - SCAN at k+2, with sep_reset_o=0.
- W-th window handshake at m:
  - DONE at m+1: done_o=1, sep_reset_o=1, frame_cnt_o updated.
  - IDLE at m+2.
- Minimum frame time: N + W + 3 cycles after start acceptance, given no stalls.
- reset_i asserted mid-frame: all outputs return to reset values immediately (asynchronously); a partial frame is discarded.

## Structure
- Shared package sobel_pkg holds:
  - the state enum typedef (IDLE, LOAD, FLUSH, SCAN, DONE);
  - an address-width function for aw;
  - the window-count function for W.
- Single module, no sub-modules. The separator and RAM are instantiated beside it at the next level up.

## Test plan
- 4x4 default frame: start_i then pixels 0..15 streamed with valid held high:
  - wr_addr_o/wr_data_o run 0..15 on consecutive cycles;
  - sep_reset_o falls 2 cycles after pixel 15;
  - 4 window handshakes give done_o for one cycle, frame_cnt_o=1, then IDLE.
- Backpressure:
  - pix_valid_i toggles every other cycle: exactly 16 writes, no duplicate addresses;
  - win_ready_i low for 5 cycles while win_valid_i is high: no window counted, done_o waits.
- abort_i in LOAD after 7 pixels: IDLE next cycle, pix_ready_o=0, no done_o, frame_cnt_o unchanged. A fresh start then writes from address 0.
- Async reset_i pulse mid-SCAN with no clock edge: sep_reset_o=1, busy_o=0, frame_cnt_o=0 immediately.
- start_i held high continuously for 3 frames on a 5x3 frame (W=3): frame_cnt_o counts 1, 2, 3; each frame has 15 writes and 3 counted windows.
- 256 back-to-back frames: frame_cnt_o wraps 255→0 on the 256th done_o.
